// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Purpose  : Per-instruction control sequencer for the ALU datapath. Runs
//            the fetch steps (T0-T2) and the execute steps (T3-T6), decodes
//            the latched IR word, and drives the datapath's bus-enable and
//            register-load strobes as Moore outputs of state and IR.
// Ports    : i_clk          clock, rising edge
//            i_clr          asynchronous active-high reset
//            i_ir           datapath IR: opcode[31:27] ra[26:23] rb[22:19] rc[18:15]
//            i_mem_ready    memory read data valid this cycle
//            i_stop         pause request, sampled at retire and in IDLE
//            o_PCout .. o_MDRout          bus drivers
//            o_MARin .. o_Read            load/control strobes
//            o_reg_out_en / o_reg_out_sel GPR bus source
//            o_reg_in_en  / o_reg_in_sel  GPR bus destination
//            o_operation    ALU op code (valid in T4 only)
//            o_run          high unless halted or in reset
//            o_illegal      one-cycle pulse on an undefined opcode
//            o_instr_count  retired-instruction counter (wraps)
// Macro    : ALU_SEQ_MULDIV_EN enables mul/div (T6, HIin/LOin/ZHighout).
//            Undefined: mul/div opcodes decode as illegal.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic [31:0]      i_ir,
    input  logic             i_mem_ready,
    input  logic             i_stop,
    output logic             o_PCout,
    output logic             o_Zlowout,
    output logic             o_ZHighout,
    output logic             o_MDRout,
    output logic             o_MARin,
    output logic             o_PCin,
    output logic             o_MDRin,
    output logic             o_IRin,
    output logic             o_Yin,
    output logic             o_Zin,
    output logic             o_HIin,
    output logic             o_LOin,
    output logic             o_IncPC,
    output logic             o_Read,
    output logic             o_reg_out_en,
    output logic [3:0]       o_reg_out_sel,
    output logic             o_reg_in_en,
    output logic [3:0]       o_reg_in_sel,
    output logic [4:0]       o_operation,
    output logic             o_run,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_instr_count
);

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_T0   = 4'd1;
    localparam logic [3:0] ST_T1   = 4'd2;
    localparam logic [3:0] ST_T1W  = 4'd3;
    localparam logic [3:0] ST_T2   = 4'd4;
    localparam logic [3:0] ST_T3   = 4'd5;
    localparam logic [3:0] ST_T4   = 4'd6;
    localparam logic [3:0] ST_T5   = 4'd7;
`ifdef ALU_SEQ_MULDIV_EN
    localparam logic [3:0] ST_T6   = 4'd8;
`endif
    localparam logic [3:0] ST_HALT = 4'd9;

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic             w_retire;
    logic [CNT_W-1:0] r_count;

    logic [4:0] w_opc;
    logic [3:0] w_ra;
    logic [3:0] w_rb;
    logic [3:0] w_rc;
    logic       w_is_binop;
    logic       w_is_unop;
    logic       w_is_muldiv;
    logic       w_is_nop;
    logic       w_is_halt;
    logic       w_is_alu;
    logic       w_illegal_op;
    logic       w_unused_ir;

    assign w_opc       = i_ir[31:27];
    assign w_ra        = i_ir[26:23];
    assign w_rb        = i_ir[22:19];
    assign w_rc        = i_ir[18:15];
    assign w_unused_ir = ^i_ir[14:0];

    // add..rol occupy the contiguous opcode range 0..8
    assign w_is_binop  = (w_opc <= 5'd8);
    assign w_is_unop   = (w_opc == 5'd17) || (w_opc == 5'd18);
`ifdef ALU_SEQ_MULDIV_EN
    assign w_is_muldiv = (w_opc == 5'd15) || (w_opc == 5'd16);
`else
    assign w_is_muldiv = 1'b0;
`endif
    assign w_is_nop     = (w_opc == 5'd26);
    assign w_is_halt    = (w_opc == 5'd27);
    assign w_is_alu     = w_is_binop | w_is_unop | w_is_muldiv;
    assign w_illegal_op = ~(w_is_alu | w_is_nop | w_is_halt);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; w_retire marks the cycle an instruction completes
    // ------------------------------------------------------------------
    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            ST_IDLE: w_next = i_stop ? ST_IDLE : ST_T0;
            ST_T0:   w_next = ST_T1;
            ST_T1:   w_next = i_mem_ready ? ST_T2 : ST_T1W;
            ST_T1W:  w_next = i_mem_ready ? ST_T2 : ST_T1W;
            ST_T2:   w_next = ST_T3;
            ST_T3: begin
                if (w_is_halt) begin
                    w_next = ST_HALT;
                end else if (w_is_alu) begin
                    w_next = ST_T4;
                end else begin
                    // nop and illegal opcodes both retire straight from decode
                    w_retire = 1'b1;
                    w_next   = i_stop ? ST_IDLE : ST_T0;
                end
            end
            ST_T4:   w_next = ST_T5;
            ST_T5: begin
`ifdef ALU_SEQ_MULDIV_EN
                if (w_is_muldiv) begin
                    w_next = ST_T6;
                end else begin
                    w_retire = 1'b1;
                    w_next   = i_stop ? ST_IDLE : ST_T0;
                end
`else
                w_retire = 1'b1;
                w_next   = i_stop ? ST_IDLE : ST_T0;
`endif
            end
`ifdef ALU_SEQ_MULDIV_EN
            ST_T6: begin
                w_retire = 1'b1;
                w_next   = i_stop ? ST_IDLE : ST_T0;
            end
`endif
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode (state + IR only)
    // ------------------------------------------------------------------
    always_comb begin
        o_PCout       = 1'b0;
        o_Zlowout     = 1'b0;
        o_MDRout      = 1'b0;
        o_MARin       = 1'b0;
        o_PCin        = 1'b0;
        o_MDRin       = 1'b0;
        o_IRin        = 1'b0;
        o_Yin         = 1'b0;
        o_Zin         = 1'b0;
        o_IncPC       = 1'b0;
        o_Read        = 1'b0;
        o_reg_out_en  = 1'b0;
        o_reg_out_sel = 4'd0;
        o_reg_in_en   = 1'b0;
        o_reg_in_sel  = 4'd0;
        o_operation   = 5'd0;
        o_illegal     = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
        o_ZHighout    = 1'b0;
        o_HIin        = 1'b0;
        o_LOin        = 1'b0;
`endif
        case (r_state)
            ST_T0: begin
                o_PCout = 1'b1;
                o_MARin = 1'b1;
                o_IncPC = 1'b1;
                o_Zin   = 1'b1;
            end
            ST_T1: begin
                o_Zlowout = 1'b1;
                o_PCin    = 1'b1;
                o_Read    = 1'b1;
                o_MDRin   = 1'b1;
            end
            // wait states keep the read alive but must not reload PC again
            ST_T1W: begin
                o_Read  = 1'b1;
                o_MDRin = 1'b1;
            end
            ST_T2: begin
                o_MDRout = 1'b1;
                o_IRin   = 1'b1;
            end
            ST_T3: begin
                if (w_is_alu) begin
                    o_reg_out_en  = 1'b1;
                    o_reg_out_sel = w_rb;
                    o_Yin         = 1'b1;
                end else if (w_illegal_op) begin
                    o_illegal = 1'b1;
                end
            end
            ST_T4: begin
                o_reg_out_en  = 1'b1;
                o_reg_out_sel = w_is_unop ? w_rb : w_rc;
                o_Zin         = 1'b1;
                o_operation   = w_opc;
            end
            ST_T5: begin
                o_Zlowout = 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
                if (w_is_muldiv) begin
                    o_LOin = 1'b1;
                end else begin
                    o_reg_in_en  = 1'b1;
                    o_reg_in_sel = w_ra;
                end
`else
                o_reg_in_en  = 1'b1;
                o_reg_in_sel = w_ra;
`endif
            end
`ifdef ALU_SEQ_MULDIV_EN
            ST_T6: begin
                o_ZHighout = 1'b1;
                o_HIin     = 1'b1;
            end
`endif
            default: ;
        endcase
    end

`ifndef ALU_SEQ_MULDIV_EN
    assign o_ZHighout = 1'b0;
    assign o_HIin     = 1'b0;
    assign o_LOin     = 1'b0;
`endif

    // run follows clr directly so it drops with the asynchronous reset
    assign o_run = ~i_clr & (r_state != ST_HALT);

    // ------------------------------------------------------------------
    // Retired-instruction counter
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (w_retire) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_instr_count = r_count;

endmodule
`default_nettype wire

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Control sequencer that drives the datapath's bus-enable and register-load strobes for one ALU instruction at a time. It runs the fetch (T0–T2) and execute (T3–T6) steps that benches currently hand-drive. It decodes the IR word the datapath latched and emits per-cycle control signals. It sits directly upstream of `datapath`, and its outputs connect 1:1 to the matching datapath inputs.

## Interface
Parameters:
- `CNT_W`, 16, width of the retired-instruction counter.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `clr`  in  1  reset, asynchronous, active-high.
- `ir`  in  32  datapath IR contents. Fields: opcode [31:27], ra [26:23], rb [22:19], rc [18:15].
- `mem_ready`  in  1  memory read data valid this cycle.
- `stop`  in  1  request to pause between instructions.
- `PCout, Zlowout, ZHighout, MDRout`  out  1 each  bus drivers.
- `MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin, IncPC, Read`  out  1 each  load/control strobes.
- `reg_out_en`  out  1  drive GPR `reg_out_sel` onto the bus.
- `reg_out_sel`  out  4  source GPR index.
- `reg_in_en`  out  1  load GPR `reg_in_sel` from the bus.
- `reg_in_sel`  out  4  destination GPR index.
- `operation`  out  5  ALU op code.
- `run`  out  1  high unless halted or in reset.
- `illegal`  out  1  one-cycle pulse on an undefined opcode.
- `instr_count`  out  CNT_W  retired instructions.

## Operation
- States: IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, HALT. Outputs are Moore (decoded from state and `ir` only). Every strobe not listed for a state is 0.
- IDLE: no strobes. Go to T0 when `stop`=0.
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin.
  - `mem_ready`=1 → T2.
  - Else → T1W.
- T1W: Read, MDRin. Stay until `mem_ready`=1, then T2. PC is not reloaded.
- T2: MDRout, IRin → T3.
- Opcode decode (in T3): 00000 add, 00001 sub, 00010 and, 00011 or, 00100 shr, 00101 shra, 00110 shl, 00111 ror, 01000 rol, 01111 mul, 10000 div, 10001 neg, 10010 not, 11010 nop, 11011 halt.
- Special opcodes in T3:
  - nop: retires from T3 with no strobes.
  - halt: → HALT.
  - Any other undefined opcode: `illegal`=1 for that cycle, no strobes, instruction retires (counted).
- T3 (ALU ops): reg_out_en, reg_out_sel=rb, Yin.
- T4: reg_out_en, reg_out_sel=rc, Zin, operation=ir[31:27].
  - neg/not use rb instead of rc.
  - `operation`=0 in every other state.
- T5: Zlowout.
  - Binary/unary ops: reg_in_en, reg_in_sel=ra; retire.
  - mul/div: LOin → T6.
- T6: ZHighout, HIin; retire.
- Retire: `instr_count` += 1 (wraps at 2^CNT_W). Next state is T0 if `stop`=0, IDLE if `stop`=1.
- HALT: all strobes 0, `run`=0. Only `clr` exits.

## Timing
- Reset (async): state=IDLE, `instr_count`=0, all outputs 0.
- `clr` mid-instruction aborts immediately. Strobes drop asynchronously. No retire.
- First T0 is the first edge after `clr` falls with `stop`=0.
- ALU op latency, T0 to retire with `mem_ready` held high:
  - 6 cycles for a 3-operand op.
  - 7 cycles for mul/div.
  - 3 cycles + 1 decode cycle for nop.
- Each cycle `mem_ready` is low in T1/T1W adds exactly one cycle.
- `stop` is sampled only at retire and in IDLE. Raising it mid-instruction does not shorten that instruction.
- `ir` must be stable from the edge ending T2 through retire. The block does not latch it.
- Retire with `stop`=0: no bubble, the next T0 follows directly.

## Configuration
- `ALU_SEQ_MULDIV_EN` defined: mul/div run T3–T6 as above.
- Undefined: opcodes 01111 and 10000 are illegal. No T6 state exists, and HIin/LOin/ZHighout are tied 0.

## Test plan
- SHRA: `ir`=0x28918000, `mem_ready`=1.
  - T4: operation=00101, reg_out_sel=3.
  - T5: reg_in_sel=1, reg_in_en=1.
  - `instr_count` 0→1 after 6 cycles.
- Memory stall: `mem_ready` low for 3 cycles in T1.
  - T1, then 3×T1W with Read/MDRin high and PCin low only after the T1 cycle.
  - T2 follows; total latency 9.
- mul (macro on): `ir`=0x78918000.
  - T5: Zlowout+LOin.
  - T6: ZHighout+HIin.
  - No reg_in_en.
  - With the macro off, the same `ir` gives `illegal`=1 in T3 and retires after 4 cycles.
- halt: `ir`=0xD8000000 → HALT, `run`=0 and strobes 0 for 20 cycles; `clr` → IDLE, `run`=1.
- Reset mid-op: assert `clr` during T4 → strobes 0 immediately, `instr_count` unchanged (0).
- stop: `stop`=1 at retire → IDLE. Drop `stop` → T0 on the next edge.
